uart_byte_tx: RTL and testbench

Serial byte transmitter that drains bytes produced by the camera digitizer and sends them over the UART link to the host.
- Accepts one byte per `new_data` strobe and reports `busy` back to the digitizer, which uses it for flow control.
- Honours a host-side `block` (flow-control hold) input.
- Frame format: 8N1, LSB first, fixed baud derived from the system clock.

---
 rtl/uart_byte_tx.sv | 150 +++++++++++++++
 tb/tb_uart_byte_tx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 serial byte transmitter, LSB first; UART_TX_PARITY_EN adds an even-parity cell.
// Latency: the start bit is on tx the cycle after the accept edge; busy spans 10 (11) bit cells.
// Backpressure: busy high refuses new_data, which is dropped; block holds off new frames in IDLE.
module uart_byte_tx #(
    parameter int CLK_RATE     = 50000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_RATE / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       new_data,
    input  logic       block,
    output logic       busy,
    output logic       tx
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            baud_tick;
`ifdef UART_TX_PARITY_EN
    logic            parity_q, parity_d;
`endif

    assign baud_tick = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        // Every non-idle state spends exactly one bit cell, timed by the shared baud counter.
        if (state_q != S_IDLE) begin
            baud_d = baud_tick ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (new_data && !block) begin
                    shift_d = data;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = S_START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^data;
`endif
                end
            end
            S_START: begin
                if (baud_tick) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_tick) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (baud_tick) begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx at CLKS_PER_BIT=10: directed scenarios plus random traffic,
// every cycle checked against a frame-countdown model of the serial line.
module tb_uart_byte_tx;

    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NC = 11;
`else
    localparam int NC = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       new_data;
    logic       block;
    logic       busy;
    logic       tx;

    int tests = 0;
    int fails = 0;

    uart_byte_tx #(.CLK_RATE(1000), .BAUD(100)) dut (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .new_data (new_data),
        .block    (block),
        .busy     (busy),
        .tx       (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    // Model: a frame is a list of line cells plus a countdown of the cycles it still owns.
    int   m_cnt = 0;
    logic m_cells [NC];

    always @(posedge clk) begin
        if (rst !== 1'b1) begin
            m_cnt = 0;
        end else if (m_cnt == 0) begin
            if (new_data && !block) begin
                m_cells[0] = 1'b0;
                for (int i = 0; i < 8; i++) m_cells[i+1] = data[i];
`ifdef UART_TX_PARITY_EN
                m_cells[9] = ^data;
`endif
                m_cells[NC-1] = 1'b1;
                m_cnt = NC * CPB;
            end
        end else begin
            m_cnt = m_cnt - 1;
        end
    end

    logic chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            logic exp_tx;
            exp_tx = (m_cnt > 0) ? m_cells[(NC*CPB - m_cnt) / CPB] : 1'b1;
            check("tx_vs_model", {31'd0, tx}, {31'd0, exp_tx});
            check("busy_vs_model", {31'd0, busy}, {31'd0, m_cnt > 0});
        end
    end

    // Observed frame: cell values sampled mid-cell, busy run length, frame count.
    int            run = 0;
    int            last_len = 0;
    int            frames = 0;
    logic [NC-1:0] seen = '0;

    always @(negedge clk) begin
        if (busy === 1'b1) begin
            if ((run % CPB) == CPB/2 && (run / CPB) < NC) seen[run / CPB] = tx;
            run++;
        end else begin
            if (run > 0) begin
                last_len = run;
                frames++;
            end
            run = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_bound", {31'd0, n < 2000}, 32'd1);
    endtask

    task automatic send(input logic [7:0] d);
        data     = d;
        new_data = 1'b1;
        @(negedge clk);
        new_data = 1'b0;
    endtask

    initial begin
        int f0;
        rst      = 1'b0;
        new_data = 1'b1;
        data     = 8'hFF;
        block    = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;

        // Reset held with a pending request.
        for (int i = 0; i < 3; i++) begin
            check("rst_tx", {31'd0, tx}, 32'd1);
            check("rst_busy", {31'd0, busy}, 32'd0);
            @(negedge clk);
        end
        new_data = 1'b0;
        rst      = 1'b1;
        tick(5);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // Single byte 0xA5.
        send(8'hA5);
        check("accept_busy", {31'd0, busy}, 32'd1);
        check("accept_tx", {31'd0, tx}, 32'd0);
        wait_idle();
        tick(3);
        check("a5_busy_len", last_len, NC * CPB);
        check("a5_cells", {23'd0, seen[8:0]}, 32'h14A);
        check("a5_stop", {31'd0, seen[NC-1]}, 32'd1);

        // Overrun requests while busy are dropped.
        f0 = frames;
        send(8'h3C);
        tick(4);
        send(8'hFF);
        tick(44);
        send(8'hFF);
        wait_idle();
        tick(20);
        check("ovr_frames", frames, f0 + 1);
        check("ovr_cells", {24'd0, seen[8:1]}, 32'h3C);
        check("ovr_idle_tx", {31'd0, tx}, 32'd1);

        // Flow control hold, release, then block raised mid-frame.
        block    = 1'b1;
        new_data = 1'b1;
        data     = 8'h5A;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("blk_busy", {31'd0, busy}, 32'd0);
            check("blk_tx", {31'd0, tx}, 32'd1);
        end
        block = 1'b0;
        @(negedge clk);
        new_data = 1'b0;
        check("unblk_busy", {31'd0, busy}, 32'd1);
        check("unblk_tx", {31'd0, tx}, 32'd0);
        tick(40);
        block = 1'b1;
        wait_idle();
        tick(2);
        check("blk_mid_len", last_len, NC * CPB);
        check("blk_mid_cells", {24'd0, seen[8:1]}, 32'h5A);
        block = 1'b0;

        // Reset during data bit 3 of 0x81, then a clean 0x00 frame.
        send(8'h81);
        tick(44);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_tx", {31'd0, tx}, 32'd1);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        tick(3);
        send(8'h00);
        wait_idle();
        tick(2);
        check("zero_cells", {23'd0, seen[8:0]}, 32'd0);
        check("zero_stop", {31'd0, seen[NC-1]}, 32'd1);
        check("zero_len", last_len, NC * CPB);

`ifdef UART_TX_PARITY_EN
        send(8'h07);
        wait_idle();
        tick(2);
        check("par07_cell", {31'd0, seen[9]}, 32'd1);
        check("par07_len", last_len, 110);
        send(8'h03);
        wait_idle();
        tick(2);
        check("par03_cell", {31'd0, seen[9]}, 32'd0);
`endif

        // Random traffic with occasional block and reset.
        for (int c = 0; c < 4000; c++) begin
            data     = 8'($urandom);
            new_data = ($urandom_range(0, 7) == 0);
            block    = ($urandom_range(0, 9) == 0);
            rst      = ($urandom_range(0, 599) != 0);
            @(negedge clk);
        end
        rst      = 1'b1;
        new_data = 1'b0;
        block    = 1'b0;
        wait_idle();
        tick(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
